// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, memory size codes,
// FSM states and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // A request faults if its funct3 is not a legal load/store code for its
    // direction, or if the address is not naturally aligned for its width.
    function automatic logic is_fault(input logic write, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (write)
            illegal = (funct3 > F3_W);
        else
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0])
                   || ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal | misaligned;
    endfunction

    function automatic logic [1:0] size_of(input logic [1:0] width);
        case (width)
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of low-aligned load data according to the load funct3.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    always_comb begin
        case (funct3)
            F3_B:    data = {{24{rdata[7]}}, rdata[7:0]};
            F3_H:    data = {{16{rdata[15]}}, rdata[15:0]};
            F3_W:    data = rdata;
            F3_BU:   data = {24'd0, rdata[7:0]};
            F3_HU:   data = {16'd0, rdata[15:0]};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, a single-cycle memory access, and a
// registered, backpressure-aware tagged response.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic              mem_signed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_write,
    output logic              resp_fault
);

    state_t              state, state_next;
    logic                r_write;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [TAG_W-1:0]    r_tag;
    logic                r_fault;
    logic [31:0]         r_data;
    logic [31:0]         ext_data;
    logic                req_fire;
    logic                req_fault;

    assign req_ready  = (state == IDLE) & ~rst;
    assign req_fire   = req_valid & req_ready;
    assign req_fault  = is_fault(req_write, req_funct3, req_addr[1:0]);
    assign mem_signed = 1'b0;

    lsu_load_ext u_load_ext (
        .funct3 (r_funct3),
        .rdata  (mem_rdata),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_tag    <= '0;
            r_fault  <= 1'b0;
            r_data   <= 32'd0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_tag    <= req_tag;
                r_fault  <= req_fault;
                r_data   <= 32'd0;
            end
            if (state == ACCESS && !r_write)
                r_data <= ext_data;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = 2'b00;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_data  = 32'd0;
        resp_tag   = '0;
        resp_write = 1'b0;
        resp_fault = 1'b0;

        case (state)
            IDLE:    if (req_fire) state_next = req_fault ? RESP : ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Strobes are gated by rst so an aborted store never reaches memory.
        if (state == ACCESS && !rst) begin
            mem_read  = ~r_write;
            mem_write = r_write;
            mem_size  = size_of(r_funct3[1:0]);
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
        end

        if (state == RESP && !rst) begin
            resp_valid = 1'b1;
            resp_data  = r_data;
            resp_tag   = r_tag;
            resp_write = r_write;
            resp_fault = r_fault;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a byte-array memory model and a
// standalone check of the load extension block.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        resp_write;
    logic        resp_fault;

    logic [7:0]  mem [256];
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [7:0]  poke_data;
    int          wr_count;
    int          rd_count;

    logic [2:0]  ext_f3;
    logic [31:0] ext_rdata;
    logic [31:0] ext_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(8), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_tag    (req_tag),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_size   (mem_size),
        .mem_signed (mem_signed),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .resp_write (resp_write),
        .resp_fault (resp_fault)
    );

    lsu_load_ext u_ext (
        .funct3 (ext_f3),
        .rdata  (ext_rdata),
        .data   (ext_data)
    );

    // Little-endian memory: zero-extended low-aligned reads, sized writes.
    always_comb begin
        mem_rdata = 32'd0;
        if (mem_read) begin
            case (mem_size)
                2'b00:   mem_rdata = {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2],
                                      mem[mem_addr + 8'd1], mem[mem_addr]};
                2'b01:   mem_rdata = {16'd0, mem[mem_addr + 8'd1], mem[mem_addr]};
                default: mem_rdata = {24'd0, mem[mem_addr]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (mem_read) rd_count <= rd_count + 1;
        if (mem_write) begin
            wr_count <= wr_count + 1;
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_size != 2'b10) mem[mem_addr + 8'd1] <= mem_wdata[15:8];
            if (mem_size == 2'b00) begin
                mem[mem_addr + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk); #1;
        poke_en   = 1'b0;
    endtask

    task automatic check_ext(input logic [2:0] f3, input logic [31:0] rd, input logic [31:0] exp);
        ext_f3    = f3;
        ext_rdata = rd;
        #1;
        check("load_ext", ext_data, exp);
    endtask

    // Full transaction with resp_ready high; called #1 after an edge in IDLE.
    task automatic do_req(input string name, input logic w, input logic [2:0] f3,
                          input logic [7:0] a, input logic [31:0] wd, input logic [4:0] tg,
                          input logic exp_fault, input logic [1:0] exp_size,
                          input logic [31:0] exp_data);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_tag    = tg;
        check({name, " req_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!exp_fault) begin
            check({name, " mem_read"}, mem_read, !w);
            check({name, " mem_write"}, mem_write, w);
            check({name, " mem_size"}, mem_size, exp_size);
            check({name, " mem_addr"}, mem_addr, a);
            if (w) check({name, " mem_wdata"}, mem_wdata, wd);
            check({name, " resp_valid early"}, resp_valid, 0);
            @(posedge clk); #1;
        end else begin
            check({name, " no strobes"}, {mem_read, mem_write}, 0);
        end
        check({name, " resp_valid"}, resp_valid, 1);
        check({name, " resp_data"}, resp_data, exp_data);
        check({name, " resp_tag"}, resp_tag, tg);
        check({name, " resp_fault"}, resp_fault, exp_fault);
        check({name, " resp_write"}, resp_write, w);
        @(posedge clk); #1;
        check({name, " back to idle"}, {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        int rd0, wr0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 8'd0;
        req_wdata  = 32'd0;
        req_tag    = 5'd0;
        resp_ready = 1'b1;
        poke_en    = 1'b0;
        poke_addr  = 8'd0;
        poke_data  = 8'd0;
        wr_count   = 0;
        rd_count   = 0;
        ext_f3     = 3'd0;
        ext_rdata  = 32'd0;

        // Standalone extension vectors.
        check_ext(3'b000, 32'h0000_00FF, 32'hFFFF_FFFF);
        check_ext(3'b000, 32'h0000_017F, 32'h0000_007F);
        check_ext(3'b001, 32'h0000_8000, 32'hFFFF_8000);
        check_ext(3'b010, 32'hCAFE_BABE, 32'hCAFE_BABE);
        check_ext(3'b100, 32'hFFFF_FFFF, 32'h0000_00FF);
        check_ext(3'b101, 32'h1234_8001, 32'h0000_8001);

        // Preload memory while reset is held.
        poke(8'h70, 8'h00); poke(8'h71, 8'h00); poke(8'h72, 8'h00); poke(8'h73, 8'h80);
        poke(8'h10, 8'h85); poke(8'h11, 8'h7F);
        poke(8'h22, 8'h5A);
        poke(8'h40, 8'h11); poke(8'h41, 8'h22); poke(8'h42, 8'h33); poke(8'h43, 8'h44);
        poke(8'hFC, 8'h01); poke(8'hFD, 8'h02); poke(8'hFE, 8'h03); poke(8'hFF, 8'h04);

        check("reset req_ready", req_ready, 0);
        check("reset strobes", {mem_read, mem_write, mem_signed}, 0);
        check("reset mem_bus", {mem_size, mem_addr}, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset resp", {resp_valid, resp_write, resp_fault, resp_tag}, 0);
        check("reset resp_data", resp_data, 0);
        rst = 1'b0;
        #1;
        check("post-reset req_ready", req_ready, 1);

        do_req("lw70", 1'b0, 3'b010, 8'h70, 32'd0, 5'd7, 1'b0, 2'b00, 32'h8000_0000);
        do_req("lb10", 1'b0, 3'b000, 8'h10, 32'd0, 5'd1, 1'b0, 2'b10, 32'hFFFF_FF85);
        do_req("lbu10", 1'b0, 3'b100, 8'h10, 32'd0, 5'd2, 1'b0, 2'b10, 32'h0000_0085);
        do_req("lh10", 1'b0, 3'b001, 8'h10, 32'd0, 5'd3, 1'b0, 2'b01, 32'h0000_7F85);

        wr0 = wr_count;
        do_req("sh20", 1'b1, 3'b001, 8'h20, 32'h1234_ABCD, 5'd4, 1'b0, 2'b01, 32'd0);
        check("sh20 one write", wr_count - wr0, 1);
        check("sh20 bytes", {mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h005A_ABCD);
        do_req("lhu20", 1'b0, 3'b101, 8'h20, 32'd0, 5'd5, 1'b0, 2'b01, 32'h0000_ABCD);
        do_req("lw_top", 1'b0, 3'b010, 8'hFC, 32'd0, 5'd31, 1'b0, 2'b00, 32'h0403_0201);

        // Faults: no memory access, response one cycle after acceptance.
        rd0 = rd_count;
        wr0 = wr_count;
        do_req("lw22 misalign", 1'b0, 3'b010, 8'h22, 32'd0, 5'd6, 1'b1, 2'b00, 32'd0);
        do_req("sh21 misalign", 1'b1, 3'b001, 8'h21, 32'hFFFF_FFFF, 5'd8, 1'b1, 2'b00, 32'd0);
        do_req("ld f3=011", 1'b0, 3'b011, 8'h00, 32'd0, 5'd9, 1'b1, 2'b00, 32'd0);
        do_req("ld f3=110", 1'b0, 3'b110, 8'h10, 32'd0, 5'd10, 1'b1, 2'b00, 32'd0);
        do_req("st f3=100", 1'b1, 3'b100, 8'h10, 32'h1, 5'd11, 1'b1, 2'b00, 32'd0);
        check("fault no reads", rd_count - rd0, 0);
        check("fault no writes", wr_count - wr0, 0);

        // Backpressure: response held, extra request ignored until next IDLE.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 8'h70;
        req_tag    = 5'd3;
        @(posedge clk); #1;
        req_funct3 = 3'b100;
        req_addr   = 8'h10;
        req_tag    = 5'd9;
        @(posedge clk); #1;
        check("bp resp_valid", resp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp hold valid", resp_valid, 1);
            check("bp hold data", resp_data, 32'h8000_0000);
            check("bp hold tag", resp_tag, 5'd3);
            check("bp req_ready", req_ready, 0);
            check("bp no strobes", {mem_read, mem_write}, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release idle", {resp_valid, req_ready, mem_read}, 3'b010);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp next access", {mem_read, mem_addr}, {1'b1, 8'h10});
        @(posedge clk); #1;
        check("bp next data", resp_data, 32'h0000_0085);
        check("bp next tag", resp_tag, 5'd9);
        @(posedge clk); #1;

        // Reset during the ACCESS cycle of a store aborts it.
        wr0 = wr_count;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 8'h40;
        req_wdata  = 32'hDEAD_BEEF;
        req_tag    = 5'd12;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst sw in access", mem_write, 1);
        rst = 1'b1;
        #1;
        check("rst gates write", mem_write, 0);
        @(posedge clk); #1;
        check("rst outputs", {req_ready, mem_read, mem_write, resp_valid, resp_tag}, 0);
        check("rst mem_bus", {mem_size, mem_addr}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst no response", resp_valid, 0);
        check("rst no write", wr_count - wr0, 0);
        do_req("lw40 after rst", 1'b0, 3'b010, 8'h40, 32'd0, 5'd13, 1'b0, 2'b00, 32'h4433_2211);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
